// File: rtl/suma_entry_ctrl.sv
// Keypad entry sequencer for the three-digit BCD adder path.
// Builds operands A and B from single-cycle key events and handles backspace,
// clear and add/equals keys. It requests a calculation, waits for the result
// with a timeout, and registers the value presented to the display mux.
module suma_entry_ctrl #(
    parameter int unsigned DIGITS  = 3,
    parameter int unsigned TIMEOUT = 64,
    parameter logic [3:0]  KEY_ADD = 4'hA,
    parameter logic [3:0]  KEY_BS  = 4'hB,
    parameter logic [3:0]  KEY_CLR = 4'hC,
    parameter logic [3:0]  KEY_EQ  = 4'hE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            key_code,
    input  logic                  key_valid,
    output logic [4*DIGITS-1:0]   op_a_bcd,
    output logic [4*DIGITS-1:0]   op_b_bcd,
    output logic                  calc_start,
    input  logic                  calc_done,
    input  logic [15:0]           calc_result,
    output logic [15:0]           disp_bcd,
    output logic                  err,
    output logic [2:0]            state_dbg
);

    localparam int unsigned OW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(DIGITS + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_A    = 3'd0;
    localparam logic [2:0] S_B    = 3'd1;
    localparam logic [2:0] S_REQ  = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_SHOW = 3'd4;

    localparam logic [CW-1:0] CNT_MAX  = CW'(DIGITS);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [2:0]    state_q, state_d;
    logic [OW-1:0] op_a_q, op_a_d;
    logic [OW-1:0] op_b_q, op_b_d;
    logic [CW-1:0] cnt_a_q, cnt_a_d;
    logic [CW-1:0] cnt_b_q, cnt_b_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    logic          start_q, start_d;
    logic [15:0]   disp_q, disp_d;

    logic key_digit_s, key_add_s, key_bs_s, key_clr_s, key_eq_s;

    assign key_digit_s = key_valid && (key_code <= 4'd9);
    assign key_add_s   = key_valid && (key_code == KEY_ADD);
    assign key_bs_s    = key_valid && (key_code == KEY_BS);
    assign key_clr_s   = key_valid && (key_code == KEY_CLR);
    assign key_eq_s    = key_valid && (key_code == KEY_EQ);

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_A;
            op_a_q  <= '0;
            op_b_q  <= '0;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            disp_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            start_q <= start_d;
            disp_q  <= disp_d;
        end
    end

    // Next state plus operand, count, timeout and error updates from keys and done.
    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        err_d   = err_q;
        tmo_d   = '0;
        case (state_q)
            S_A: begin
                if (key_digit_s) begin
                    if (cnt_a_q < CNT_MAX) begin
                        op_a_d  = (op_a_q << 4) | OW'(key_code);
                        cnt_a_d = cnt_a_q + CW'(1);
                    end else begin
                        op_a_d = op_a_q;
                    end
                end else if (key_bs_s) begin
                    if (cnt_a_q != '0) begin
                        op_a_d  = op_a_q >> 4;
                        cnt_a_d = cnt_a_q - CW'(1);
                    end else begin
                        op_a_d = op_a_q;
                    end
                end else if (key_add_s) begin
                    if (cnt_a_q != '0) begin
                        state_d = S_B;
                    end else begin
                        state_d = S_A;
                    end
                end else if (key_clr_s) begin
                    op_a_d = '0; op_b_d = '0; cnt_a_d = '0; cnt_b_d = '0; err_d = 1'b0;
                end else begin
                    state_d = S_A;
                end
            end
            S_B: begin
                if (key_digit_s) begin
                    if (cnt_b_q < CNT_MAX) begin
                        op_b_d  = (op_b_q << 4) | OW'(key_code);
                        cnt_b_d = cnt_b_q + CW'(1);
                    end else begin
                        op_b_d = op_b_q;
                    end
                end else if (key_bs_s) begin
                    // Backspace on an empty B returns to editing A.
                    if (cnt_b_q != '0) begin
                        op_b_d  = op_b_q >> 4;
                        cnt_b_d = cnt_b_q - CW'(1);
                    end else begin
                        state_d = S_A;
                    end
                end else if (key_eq_s) begin
                    if (cnt_b_q != '0) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_B;
                    end
                end else if (key_clr_s) begin
                    op_a_d = '0; op_b_d = '0; cnt_a_d = '0; cnt_b_d = '0; err_d = 1'b0;
                    state_d = S_A;
                end else begin
                    state_d = S_B;
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Done beats the timeout when both land on the terminal cycle.
                if (calc_done) begin
                    state_d = S_SHOW;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_SHOW;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_SHOW: begin
                if (key_digit_s) begin
                    op_a_d  = OW'(key_code);
                    cnt_a_d = CW'(1);
                    op_b_d  = '0;
                    cnt_b_d = '0;
                    err_d   = 1'b0;
                    state_d = S_A;
                end else if (key_clr_s) begin
                    op_a_d = '0; op_b_d = '0; cnt_a_d = '0; cnt_b_d = '0; err_d = 1'b0;
                    state_d = S_A;
                end else begin
                    state_d = S_SHOW;
                end
            end
            default: begin
                state_d = S_A;
            end
        endcase
    end

    // Registered outputs: start pulse and display value derived from the next state.
    always_comb begin
        start_d = (state_d == S_REQ);
        disp_d  = 16'h0000;
        case (state_d)
            S_A:                   disp_d = 16'(op_a_d);
            S_B, S_REQ, S_WAIT:    disp_d = 16'(op_b_d);
            S_SHOW: begin
                if (state_q == S_WAIT) begin
                    disp_d = calc_done ? calc_result : 16'h0000;
                end else begin
                    disp_d = disp_q;
                end
            end
            default:               disp_d = 16'h0000;
        endcase
    end

    assign op_a_bcd   = op_a_q;
    assign op_b_bcd   = op_b_q;
    assign calc_start = start_q;
    assign disp_bcd   = disp_q;
    assign err        = err_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_suma_entry_ctrl.sv
// Self-checking bench for suma_entry_ctrl: directed scenarios followed by
// random key/done traffic, compared against a decimal-valued reference model.
module tb_suma_entry_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        key_valid = 1'b0;
    logic [11:0] op_a_bcd, op_b_bcd;
    logic        calc_start;
    logic        calc_done = 1'b0;
    logic [15:0] calc_result = 16'h0000;
    logic [15:0] disp_bcd;
    logic        err;
    logic [2:0]  state_dbg;

    int errors = 0;
    int checks = 0;
    int n_start = 0;
    int pend = 0;

    // Reference model: operands held as decimal integers with digit counts.
    int          m_st = 0;
    int          m_a = 0, m_al = 0, m_b = 0, m_bl = 0, m_wait = 0;
    logic        m_err = 1'b0;
    logic [15:0] m_disp = 16'h0000;

    suma_entry_ctrl dut (
        .clk(clk), .rst_n(rst_n), .key_code(key_code), .key_valid(key_valid),
        .op_a_bcd(op_a_bcd), .op_b_bcd(op_b_bcd), .calc_start(calc_start),
        .calc_done(calc_done), .calc_result(calc_result), .disp_bcd(disp_bcd),
        .err(err), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[3:0]   = 4'((v)        % 10);
        r[7:4]   = 4'((v / 10)   % 10);
        r[11:8]  = 4'((v / 100)  % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        m_a = 0; m_al = 0; m_b = 0; m_bl = 0; m_err = 1'b0; m_st = 0;
    endtask

    task automatic model(input logic r, input logic kv, input logic [3:0] k,
                         input logic d, input logic [15:0] res);
        int kd;
        kd = int'(k);
        if (!r) begin
            clear_model(); m_disp = 16'h0000; m_wait = 0; pend = 0;
        end else begin
            case (m_st)
                0: if (kv) begin
                    if (kd <= 9) begin
                        if (m_al < 3) begin m_a = m_a * 10 + kd; m_al++; end
                    end else if (kd == 11) begin
                        if (m_al > 0) begin m_a = m_a / 10; m_al--; end
                    end else if (kd == 10) begin
                        if (m_al > 0) m_st = 1;
                    end else if (kd == 12) clear_model();
                end
                1: if (kv) begin
                    if (kd <= 9) begin
                        if (m_bl < 3) begin m_b = m_b * 10 + kd; m_bl++; end
                    end else if (kd == 11) begin
                        if (m_bl > 0) begin m_b = m_b / 10; m_bl--; end
                        else m_st = 0;
                    end else if (kd == 14) begin
                        if (m_bl > 0) m_st = 2;
                    end else if (kd == 12) clear_model();
                end
                2: begin m_st = 3; m_wait = 0; end
                3: begin
                    if (d) begin m_disp = res; m_st = 4; m_wait = 0; end
                    else if (m_wait == 63) begin m_err = 1'b1; m_disp = 16'h0000; m_st = 4; m_wait = 0; end
                    else m_wait++;
                end
                default: if (kv) begin
                    if (kd <= 9) begin
                        m_a = kd; m_al = 1; m_b = 0; m_bl = 0; m_err = 1'b0; m_st = 0;
                    end else if (kd == 12) clear_model();
                end
            endcase
        end
    endtask

    task automatic step(input logic r, input logic kv, input logic [3:0] k,
                        input logic d, input logic [15:0] res);
        logic [15:0] e_disp;
        rst_n = r; key_valid = kv; key_code = k; calc_done = d; calc_result = res;
        @(posedge clk);
        model(r, kv, k, d, res);
        #1;
        if (m_st == 0) e_disp = to_bcd(m_a);
        else if (m_st == 4) e_disp = m_disp;
        else e_disp = to_bcd(m_b);
        chk("op_a", 16'(op_a_bcd), to_bcd(m_a));
        chk("op_b", 16'(op_b_bcd), to_bcd(m_b));
        chk("state", 16'(state_dbg), 16'(m_st));
        chk("err", 16'(err), 16'(m_err));
        chk("start", 16'(calc_start), 16'(m_st == 2));
        chk("disp", disp_bcd, e_disp);
        if (calc_start) n_start++;
    endtask

    task automatic key(input logic [3:0] k);
        step(1'b1, 1'b1, k, 1'b0, 16'h0000);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 4'h0, 1'b0, 16'h0000);
    endtask

    initial begin
        logic        d;
        logic [15:0] res;
        // Reset state.
        step(1'b0, 1'b0, 4'h0, 1'b0, 16'h0000);
        chk("rst_state", 16'(state_dbg), 16'h0000);
        chk("rst_disp", disp_bcd, 16'h0000);

        // Plan 1: 123 + 456, done five cycles after start.
        n_start = 0;
        key(4'h1); key(4'h2); key(4'h3); key(4'hA);
        key(4'h4); key(4'h5); key(4'h6); key(4'hE);
        for (int i = 0; i < 4; i++) idle();
        step(1'b1, 1'b0, 4'h0, 1'b1, 16'h0579);
        idle(); idle();
        chk("p1_op_a", 16'(op_a_bcd), 16'h0123);
        chk("p1_op_b", 16'(op_b_bcd), 16'h0456);
        chk("p1_disp", disp_bcd, 16'h0579);
        chk("p1_state", 16'(state_dbg), 16'h0004);
        chk("p1_nstart", 16'(n_start), 16'h0001);

        // Plan 6b: clear from S_SHOW.
        key(4'hC);
        chk("p6_clr_state", 16'(state_dbg), 16'h0000);
        chk("p6_clr_ops", 16'(op_a_bcd | op_b_bcd), 16'h0000);

        // Plan 2: digit limit, EQ ignored in S_A.
        key(4'h9); key(4'h8); key(4'h7); key(4'h6);
        chk("p2_op_a", 16'(op_a_bcd), 16'h0987);
        key(4'hE);
        chk("p2_state", 16'(state_dbg), 16'h0000);

        // Plan 3: backspace behaviour.
        key(4'hC); key(4'h1); key(4'h2); key(4'hB);
        chk("p3_bs", 16'(op_a_bcd), 16'h0001);
        key(4'hA);
        chk("p3_in_b", 16'(state_dbg), 16'h0001);
        key(4'hB);
        chk("p3_back_a", 16'(state_dbg), 16'h0000);
        chk("p3_keep_a", 16'(op_a_bcd), 16'h0001);
        key(4'hB); key(4'hA);
        chk("p3_add_empty", 16'(state_dbg), 16'h0000);

        // Plan 5: keys ignored in S_WAIT, then reset aborts and late done is ignored.
        key(4'h1); key(4'hA); key(4'h2); key(4'hE); idle();
        key(4'h5); key(4'hC); key(4'hA);
        chk("p5_wait_state", 16'(state_dbg), 16'h0003);
        chk("p5_wait_a", 16'(op_a_bcd), 16'h0001);
        step(1'b0, 1'b0, 4'h0, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 4'h0, 1'b1, 16'h9999);
        chk("p5_late_state", 16'(state_dbg), 16'h0000);
        chk("p5_late_disp", disp_bcd, 16'h0000);

        // Plan 4a: timeout after exactly 64 cycles in S_WAIT.
        key(4'h4); key(4'hA); key(4'h5); key(4'hE);
        for (int i = 0; i < 64; i++) idle();
        chk("p4_still_wait", 16'(state_dbg), 16'h0003);
        idle();
        chk("p4_to_state", 16'(state_dbg), 16'h0004);
        chk("p4_to_err", 16'(err), 16'h0001);
        chk("p4_to_disp", disp_bcd, 16'h0000);

        // Plan 6a: digit in S_SHOW restarts entry and clears err.
        key(4'h7);
        chk("p6_dig_a", 16'(op_a_bcd), 16'h0007);
        chk("p6_dig_err", 16'(err), 16'h0000);

        // Plan 4b: done on the terminal cycle wins.
        key(4'hA); key(4'h8); key(4'hE);
        for (int i = 0; i < 64; i++) idle();
        step(1'b1, 1'b0, 4'h0, 1'b1, 16'h0015);
        chk("p4_term_err", 16'(err), 16'h0000);
        chk("p4_term_disp", disp_bcd, 16'h0015);

        // Random traffic with a behavioural adder returning after 1..70 cycles.
        pend = 0;
        for (int i = 0; i < 4000; i++) begin
            d = 1'b0;
            res = to_bcd(m_a + m_b);
            if (pend > 0) begin
                pend--;
                if (pend == 0) d = 1'b1;
            end
            if (!d && ($urandom_range(0, 24) == 0)) begin
                d = 1'b1;
                res = 16'($urandom);
            end
            if ($urandom_range(0, 599) == 0)
                step(1'b0, 1'($urandom), 4'($urandom), d, res);
            else
                step(1'b1, ($urandom_range(0, 2) == 0), 4'($urandom), d, res);
            if (m_st == 2) pend = $urandom_range(1, 70);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
